// File: rtl/adc0809_responder.sv
// Behavioural ADC0808/0809-class converter for system benches and FPGA loopback.
// Optional round-half-up result: define ADC_ROUNDING_EN (default build truncates).
module adc0809_responder #(
  parameter int CONV_CYCLES = 64,
  parameter int EOC_HOLD    = 4,
  parameter int IN_BITS     = 12,
  parameter int OUT_BITS    = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clk_adc,
  input  logic                ale,
  input  logic                oe,
  input  logic                address_in,
  input  logic [IN_BITS-1:0]  analog_ch0,
  input  logic [IN_BITS-1:0]  analog_ch1,
  output logic                eoc,
  output logic [OUT_BITS-1:0] data_out,
  output logic                busy,
  output logic [1:0]          state_dbg
);

  localparam int CW = $clog2(CONV_CYCLES + 1);
  localparam int HW = $clog2(EOC_HOLD + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CONVERT = 2'd1,
    S_EOC_HI  = 2'd2
  } state_t;

  state_t              state, state_next;
  logic                ale_q, clk_adc_q;
  logic                ale_rise, adc_tick;
  logic                start, finish, hold_done;
  logic [CW-1:0]       tick_cnt;
  logic [HW-1:0]       hold_cnt;
  logic [IN_BITS-1:0]  sample_reg;
  logic [OUT_BITS-1:0] result_reg;
  logic [OUT_BITS-1:0] conv_value;
  logic                unused_sample;

  assign ale_rise  = ale & ~ale_q;
  assign adc_tick  = clk_adc & ~clk_adc_q;
  assign state_dbg = state;

  // Only the upper sample bits feed the result; the rest are kept for visibility.
  assign unused_sample = ^sample_reg;

`ifdef ADC_ROUNDING_EN
  logic [OUT_BITS:0] rounded;
  assign rounded    = {1'b0, sample_reg[IN_BITS-1 -: OUT_BITS]}
                    + (OUT_BITS+1)'(sample_reg[IN_BITS-OUT_BITS-1]);
  assign conv_value = rounded[OUT_BITS] ? {OUT_BITS{1'b1}} : rounded[OUT_BITS-1:0];
`else
  assign conv_value = sample_reg[IN_BITS-1 -: OUT_BITS];
`endif

  // A fresh ALE in CONVERT restarts and takes priority over a coincident final tick.
  always_comb begin
    state_next = state;
    start      = 1'b0;
    finish     = 1'b0;
    hold_done  = 1'b0;
    case (state)
      S_IDLE: begin
        if (ale_rise) begin
          start      = 1'b1;
          state_next = S_CONVERT;
        end
      end
      S_CONVERT: begin
        if (ale_rise) begin
          start = 1'b1;
        end else if (adc_tick && (tick_cnt == CW'(CONV_CYCLES - 1))) begin
          finish     = 1'b1;
          state_next = S_EOC_HI;
        end
      end
      S_EOC_HI: begin
        if (hold_cnt == HW'(EOC_HOLD - 1)) begin
          hold_done  = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      ale_q      <= 1'b0;
      clk_adc_q  <= 1'b0;
      tick_cnt   <= '0;
      hold_cnt   <= '0;
      sample_reg <= '0;
      result_reg <= '0;
      eoc        <= 1'b0;
      busy       <= 1'b0;
      data_out   <= '0;
    end else begin
      state     <= state_next;
      ale_q     <= ale;
      clk_adc_q <= clk_adc;
      data_out  <= oe ? result_reg : '0;

      // The channel is resolved at capture time, so the sample embodies the latched address.
      if (start) begin
        sample_reg <= address_in ? analog_ch1 : analog_ch0;
        tick_cnt   <= '0;
        busy       <= 1'b1;
      end else if ((state == S_CONVERT) && adc_tick) begin
        tick_cnt <= tick_cnt + CW'(1);
      end

      if (finish) begin
        result_reg <= conv_value;
        eoc        <= 1'b1;
        hold_cnt   <= '0;
      end else if (state == S_EOC_HI) begin
        if (hold_done) begin
          eoc  <= 1'b0;
          busy <= 1'b0;
        end else begin
          hold_cnt <= hold_cnt + HW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_adc0809_responder.sv
// Self-checking bench for adc0809_responder: scoreboard of expected results per conversion.
module tb_adc0809_responder;

  localparam int CONV = 64;
  localparam int HOLD = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clk_adc = 1'b0;
  logic        ale = 1'b0;
  logic        oe = 1'b0;
  logic        address_in = 1'b0;
  logic [11:0] ch0 = '0;
  logic [11:0] ch1 = '0;
  logic        eoc;
  logic [7:0]  data_out;
  logic        busy;
  logic [1:0]  state_dbg;

  int checks = 0;
  int errors = 0;
  int adc_edges = 0;
  int conv_start = 0;
  logic [7:0] last_result = '0;
  logic [7:0] exp_q[$];

  adc0809_responder #(
    .CONV_CYCLES(CONV), .EOC_HOLD(HOLD), .IN_BITS(12), .OUT_BITS(8)
  ) dut (
    .clk(clk), .reset(reset), .clk_adc(clk_adc), .ale(ale), .oe(oe),
    .address_in(address_in), .analog_ch0(ch0), .analog_ch1(ch1),
    .eoc(eoc), .data_out(data_out), .busy(busy), .state_dbg(state_dbg)
  );

  // clock / reset block: clk 40 ns; clk_adc toggles every 4 clk, offset from both clk edges
  always #20 clk = ~clk;
  initial begin
    #10;
    forever #160 clk_adc = ~clk_adc;
  end
  always @(posedge clk_adc) adc_edges <= adc_edges + 1;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] model(input logic [11:0] s);
`ifdef ADC_ROUNDING_EN
    logic [8:0] t;
    t = {1'b0, s[11:4]} + {8'd0, s[3]};
    return t[8] ? 8'hFF : t[7:0];
`else
    return s[11:4];
`endif
  endfunction

  // driver tasks
  task automatic apply_reset(input int n);
    @(negedge clk);
    reset = 1'b1;
    repeat (n) @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    last_result = '0;
  endtask

  task automatic start_conv(input logic addr, input bit restart, input logic [7:0] exp_val);
    @(negedge clk);
    address_in = addr;
    ale = 1'b1;
    if (restart && exp_q.size() > 0) void'(exp_q.pop_back());
    exp_q.push_back(exp_val);
    @(posedge clk);
    #1 conv_start = adc_edges;
    @(negedge clk);
    ale = 1'b0;
  endtask

  task automatic wait_edges(input int n);
    for (int i = 0; i < 2000; i++) begin
      if (adc_edges - conv_start >= n) break;
      @(negedge clk);
    end
  endtask

  task automatic wait_eoc(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      if (eoc === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s_eoc_timeout: eoc not seen within 800 clk", name);
    end else begin
      checks++;
      if (adc_edges - conv_start != CONV) begin
        errors++;
        $display("FAIL %s_eoc_latency: got %0d clk_adc edges, want %0d",
                 name, adc_edges - conv_start, CONV);
      end
    end
  endtask

  // Called on the first negedge eoc is seen high; measures the pulse width.
  task automatic check_eoc_pulse(input string name, input bit poke_ale);
    int n;
    logic busy_during;
    n = 1;
    busy_during = busy;
    if (poke_ale) ale = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      ale = 1'b0;
      if (eoc !== 1'b1) break;
      n++;
    end
    checks++;
    if (n != HOLD) begin
      errors++;
      $display("FAIL %s_eoc_width: got %0d clk, want %0d", name, n, HOLD);
    end
    checks++;
    if (busy_during !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_busy_edge: during=%b after=%b, want 1 then 0", name, busy_during, busy);
    end
  endtask

  // scoreboard pop and compare on read
  task automatic read_result(input string name);
    logic [7:0] exp_val;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s_queue: no expected result pending", name);
      exp_val = 8'h00;
    end else begin
      exp_val = exp_q.pop_front();
    end
    @(negedge clk);
    oe = 1'b1;
    @(negedge clk);
    checks++;
    if (data_out !== exp_val) begin
      errors++;
      $display("FAIL %s_data: got %h, want %h", name, data_out, exp_val);
    end
    oe = 1'b0;
    @(negedge clk);
    checks++;
    if (data_out !== 8'h00) begin
      errors++;
      $display("FAIL %s_oe_off: got %h, want 00", name, data_out);
    end
    last_result = exp_val;
  endtask

  task automatic test_reset();
    apply_reset(5);
    checks++;
    if (eoc !== 1'b0 || busy !== 1'b0 || data_out !== 8'h00 || state_dbg !== 2'd0) begin
      errors++;
      $display("FAIL reset_values: eoc=%b busy=%b data=%h state=%0d, want 0 0 00 0",
               eoc, busy, data_out, state_dbg);
    end
    oe = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (data_out !== 8'h00) begin
      errors++;
      $display("FAIL reset_oe_read: got %h, want 00", data_out);
    end
    oe = 1'b0;
  endtask

  task automatic test_basic();
    ch0 = 12'h400;
    start_conv(1'b0, 1'b0, model(12'h400));
    checks++;
    if (busy !== 1'b1 || eoc !== 1'b0) begin
      errors++;
      $display("FAIL basic_busy: busy=%b eoc=%b, want 1 0", busy, eoc);
    end
    wait_eoc("basic");
    check_eoc_pulse("basic", 1'b0);
    read_result("basic");
  endtask

  task automatic test_sample_hold();
    ch0 = 12'h123;
    ch1 = 12'h800;
    start_conv(1'b1, 1'b0, model(12'h800));
    repeat (10) @(negedge clk);
    ch1 = 12'hFFF;
    oe = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (data_out !== last_result) begin
      errors++;
      $display("FAIL hold_prev_read: got %h, want %h", data_out, last_result);
    end
    oe = 1'b0;
    wait_eoc("hold");
    check_eoc_pulse("hold", 1'b0);
    read_result("hold");
  endtask

  task automatic test_restart();
    ch0 = 12'h9A5;
    start_conv(1'b0, 1'b0, model(12'h9A5));
    wait_edges(30);
    ch0 = 12'h3C0;
    start_conv(1'b0, 1'b1, model(12'h3C0));
    wait_eoc("restart");
    check_eoc_pulse("restart", 1'b0);
    read_result("restart");
  endtask

  task automatic test_ale_in_eoc();
    int busy_seen;
    ch1 = 12'h6E0;
    start_conv(1'b1, 1'b0, model(12'h6E0));
    wait_eoc("ale_eoc");
    check_eoc_pulse("ale_eoc", 1'b1);
    busy_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (busy !== 1'b0 || state_dbg !== 2'd0) busy_seen++;
    end
    checks++;
    if (busy_seen != 0) begin
      errors++;
      $display("FAIL ale_eoc_ignored: %0d cycles busy/not idle, want 0", busy_seen);
    end
    read_result("ale_eoc");
  endtask

  task automatic test_reset_abort();
    int eoc_seen;
    ch0 = 12'h555;
    start_conv(1'b0, 1'b0, model(12'h555));
    wait_edges(40);
    apply_reset(1);
    eoc_seen = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (eoc !== 1'b0) eoc_seen++;
    end
    checks++;
    if (eoc_seen != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_eoc: eoc high %0d clk, busy=%b, want 0 0", eoc_seen, busy);
    end
    oe = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (data_out !== 8'h00) begin
      errors++;
      $display("FAIL abort_result_cleared: got %h, want 00", data_out);
    end
    oe = 1'b0;
    ch1 = 12'hABC;
    start_conv(1'b1, 1'b0, model(12'hABC));
    wait_eoc("after_abort");
    check_eoc_pulse("after_abort", 1'b0);
    read_result("after_abort");
  endtask

  task automatic test_rounding();
    logic [11:0] samples [3];
    logic [7:0]  expect_v [3];
    samples[0] = 12'h7F8;
    samples[1] = 12'hFF8;
    samples[2] = 12'h7F7;
`ifdef ADC_ROUNDING_EN
    expect_v[0] = 8'h80;
    expect_v[1] = 8'hFF;
    expect_v[2] = 8'h7F;
`else
    expect_v[0] = 8'h7F;
    expect_v[1] = 8'hFF;
    expect_v[2] = 8'h7F;
`endif
    for (int k = 0; k < 3; k++) begin
      ch0 = samples[k];
      start_conv(1'b0, 1'b0, expect_v[k]);
      wait_eoc("round");
      check_eoc_pulse("round", 1'b0);
      read_result("round");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sample_hold();
    test_restart();
    test_ale_in_eoc();
    test_reset_abort();
    test_rounding();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adc0809_responder.md
Name: adc0809_responder

Overview:
Synthesizable behavioural model of the ADC0808/0809-class converter. It sits at the far end of the ADC controller's pin interface (clk_adc, ale, oe, address, eoc, data). It latches the channel address on ALE, samples the selected 12-bit "analog" word, and counts clk_adc edges for the conversion time. It then pulses EOC and drives the 8-bit result when OE is high. Used in system benches and on FPGA loopback builds in place of the real chip.

Parameters:
CONV_CYCLES, 64, clk_adc rising edges from start of conversion to EOC (minimum 1)
EOC_HOLD, 4, clk cycles EOC stays high once conversion completes (minimum 1)
IN_BITS, 12, width of each analog input word
OUT_BITS, 8, width of conversion result; result = top OUT_BITS of sample

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
clk_adc  input  1  converter clock from controller; sampled in clk domain, frequency ≤ clk/2
ale  input  1  address latch enable / start of conversion; rising edge detected in clk domain
oe  input  1  output enable
address_in  input  1  channel select, latched on ALE rising edge
analog_ch0  input  IN_BITS  channel 0 input value
analog_ch1  input  IN_BITS  channel 1 input value
eoc  output  1  end of conversion pulse
data_out  output  OUT_BITS  conversion result when enabled, else 0
busy  output  1  high from ALE edge until EOC deasserts

Behaviour:
- Reset values: eoc=0, data_out=0, busy=0, result register=0, state=IDLE, counters=0, ale_q/clk_adc_q=0.
- Edge detect: ale_rise = ale & ~ale_q; adc_tick = clk_adc & ~clk_adc_q (registered previous values).
- States: IDLE, CONVERT, EOC_HI.
- IDLE: on ale_rise, do all of the following, then go to CONVERT with busy=1:
  - latch address_in;
  - sample analog_ch0 or analog_ch1 per address_in into sample_reg;
  - clear tick counter.
- CONVERT: on each adc_tick, increment the tick counter. When the counter reaches CONV_CYCLES:
  - result_reg <= sample_reg[IN_BITS-1 -: OUT_BITS];
  - eoc <= 1;
  - clear hold counter;
  - go to EOC_HI.
- EOC_HI: eoc held high exactly EOC_HOLD clk cycles, then eoc=0, busy=0, go to IDLE (same cycle eoc drops).
- ALE rising edge in CONVERT: restart conversion (re-latch address, re-sample, counter=0); no EOC from the aborted conversion.
- ALE rising edge in EOC_HI: ignored; EOC pulse completes normally.
- Analog inputs changing after the sample are ignored until the next ALE.
- result_reg retains its last value across conversions; updated only at conversion completion.
- data_out registered: data_out <= oe ? result_reg : 0; one clk latency from oe.
- oe is independent of state; reading during CONVERT returns the previous result.
- Reset asserted mid-conversion: immediate return to reset values on that clock edge; no EOC.
- Simultaneous adc_tick and the final count in the same cycle as ale_rise in CONVERT: restart wins.

Optional Feature:
Macro ADC_ROUNDING_EN.
- Defined: result = top OUT_BITS of sample + bit (IN_BITS-OUT_BITS-1) of sample (round half up), saturating at all-ones.
- Undefined: plain truncation (top OUT_BITS).

Test Plan:
- Common setup: clk 40 ns; clk_adc = clk/8 (toggles every 4 clk); CONV_CYCLES=64.
- Reset held 5 cycles -> eoc=0, data_out=00, busy=0; oe=1 after reset -> data_out=00.
- ch0=0x400, address_in=0, ALE pulse -> busy=1 next clk; eoc rises after exactly 64 clk_adc rising edges, stays high 4 clk; oe=1 -> data_out=0x40 one clk later; oe=0 -> data_out=00.
- ch1=0x800, ch0=0x123, address_in=1, ALE; change ch1 to 0xFFF mid-conversion -> result 0x80.
- Second ALE after 30 clk_adc edges -> no EOC at edge 64 of the first conversion; EOC 64 edges after the second ALE.
- Reset asserted at edge 40 of a conversion -> eoc never pulses; busy=0; a following ALE converts normally.
- With ADC_ROUNDING_EN: sample 0x7F8 -> 0x80; 0xFF8 -> 0xFF (saturated); 0x7F7 -> 0x7F. Without the macro: 0x7F8 -> 0x7F.
